tt_um_unload: RTL
=================

TT_UM_UNLOAD -- requirements
Module: tt_um_unload

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16, rows per column (bits per beat).
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8, columns in the weight array.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  run request; rising edge starts a dump, low aborts.
REQ-006 SHALL have port ui_param  input  7  [6:3] = last row index R, [2:0] = last column index C.
REQ-007 SHALL have port ui_weights  input  MAX_IN_LEN x MAX_OUT_LEN x 2 (signed)  ternary array to read back.
REQ-008 SHALL have port ui_ready  input  1  downstream accepts the current beat.
REQ-009 SHALL have port uo_output  output  16  beat data; bit i = row i.
REQ-010 SHALL have port uo_valid  output  1  uo_output holds a beat.
REQ-011 SHALL have port uo_phase  output  1  0 = MSB beat, 1 = LSB beat.
REQ-012 SHALL have port uo_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-013 SHALL implement states IDLE, MSB, LSB, DONE.
REQ-014 IDLE: on ena=1 with previous-cycle ena=0, SHALL latch R, C, set column count=0, and enter MSB.
REQ-015 R and C SHALL be held at latched values for the whole dump; changes to ui_param mid-dump SHALL be ignored.
REQ-016 MSB: uo_output[i] SHALL be ui_weights[i][count][1] for i<=R, 0 for i>R; uo_phase=0; uo_valid=1.
REQ-017 LSB: same as MSB with bit [0]; uo_phase=1.
REQ-018 A beat SHALL be accepted only when uo_valid=1 and ui_ready=1 in the same cycle.
REQ-019 While not accepted, uo_output, uo_phase and uo_valid SHALL hold stable (backpressure).
REQ-020 Accepted MSB beat SHALL move to LSB on the same column.
REQ-021 Accepted LSB beat with count<C SHALL increment count and move to MSB.
REQ-022 Accepted LSB beat with count==C SHALL move to DONE; uo_valid SHALL drop the next cycle.
REQ-023 DONE SHALL assert uo_done for exactly one cycle and return to IDLE.
REQ-024 Outputs SHALL be registered: first beat valid the cycle after the ena rising edge.
REQ-025 Total beats per dump SHALL be 2*(C+1); C=0 SHALL yield 2 beats.
REQ-026 ena=0 in any non-IDLE state SHALL abort: next cycle IDLE, uo_valid=0, and no uo_done.
REQ-027 A held-high ena after DONE SHALL NOT restart; a new dump requires a fresh rising edge.
REQ-028 Weight value 2'b10 SHALL be passed through unmodified (no saturation).

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, count=0, uo_output=0, uo_valid=0, uo_phase=0, uo_done=0, ena history=0, and latched R and C = 0.
REQ-030 Reset mid-dump SHALL discard the dump; after release, a new ena rising edge is required.

Configuration
REQ-031 With UNLOAD_PARITY_EN defined, SHALL add output uo_parity (1 bit, registered) = XOR of uo_output, valid with uo_valid, and 0 in reset.
REQ-032 Without UNLOAD_PARITY_EN, uo_parity SHALL NOT exist and behaviour SHALL be otherwise identical.

Structure
REQ-033 Package tt_ternary_pkg SHALL hold MAX_IN_LEN/MAX_OUT_LEN defaults, the state enum, and the ternary weight typedef, shared with the loader.
REQ-034 A combinational sub-module tt_unload_beat_mux SHALL perform column select, phase bit select and row masking; the FSM, counter and registers stay in tt_um_unload.

Verification
REQ-035 R=15, C=7, ready=1 always: 16 beats on consecutive cycles; uo_done on the cycle after beat 16; data matches array.
REQ-036 R=3, C=0, weights[0..3][0] = {+1,-1,0,+1}: beats 0x0002 (MSB) then 0x0009 (LSB); bits 15:4 = 0.
REQ-037 R=15, C=1, ready toggling 1,0,0,1: each beat held stable while ready=0; 4 beats total and no duplicates.
REQ-038 ena dropped after beat 3: uo_valid=0 the next cycle, no uo_done; re-raising ena restarts at column 0 MSB.
REQ-039 rst_n pulsed low mid-LSB: all outputs 0 immediately; ui_param changed mid-dump is shown to be ignored.
REQ-040 With UNLOAD_PARITY_EN: beat 0x0007 gives uo_parity=1, beat 0x0003 gives uo_parity=0.

Source files
------------

// File: rtl/tt_ternary_pkg.sv
// Shared ternary-array definitions for the weight loader and unloader.
// Holds array size defaults, weight encoding and the unload state enum.
package tt_ternary_pkg;

    // Default array geometry: rows per column and number of columns.
    localparam int DEF_MAX_IN_LEN  = 16;
    localparam int DEF_MAX_OUT_LEN = 8;

    // Width of one output beat (one bit per row).
    localparam int OUT_W = 16;

    // One ternary weight as stored in the array.
    typedef logic signed [1:0] tern_t;

    // Weight codes as held in the array.
    localparam tern_t TERN_ZERO = 2'b00;
    localparam tern_t TERN_POS  = 2'b01;
    localparam tern_t TERN_NEG  = 2'b10;

    // Unload sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MSB,
        ST_LSB,
        ST_DONE
    } unload_state_e;

    // Pick the bit of a weight shown in the given phase (0 = MSB, 1 = LSB).
    function automatic logic tern_bit(tern_t w, logic phase);
        return phase ? w[0] : w[1];
    endfunction

endpackage

// File: rtl/tt_unload_beat_mux.sv
// Combinational beat builder: column select, phase bit select, row mask.
// Rows above the last requested row read as zero.
module tt_unload_beat_mux
    import tt_ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = DEF_MAX_IN_LEN,
    parameter int MAX_OUT_LEN = DEF_MAX_OUT_LEN
) (
    input  tern_t [MAX_IN_LEN-1:0][MAX_OUT_LEN-1:0] weights,
    input  logic  [2:0]                             col,
    input  logic                                    phase,
    input  logic  [3:0]                             last_row,
    output logic  [OUT_W-1:0]                       beat
);

    localparam int ROWS = (MAX_IN_LEN < OUT_W) ? MAX_IN_LEN : OUT_W;

    // Gather one bit of the selected column from every enabled row.
    always_comb begin
        beat = '0;
        for (int i = 0; i < ROWS; i++) begin
            if ((i <= int'(last_row)) && (int'(col) < MAX_OUT_LEN)) begin
                beat[i] = tern_bit(weights[i][col], phase);
            end
        end
    end

endmodule

// File: rtl/tt_um_unload.sv
// Ternary weight array unloader: streams MSB/LSB beats per column.
// Define UNLOAD_PARITY_EN to add a registered parity output uo_parity.
module tt_um_unload
    import tt_ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = DEF_MAX_IN_LEN,
    parameter int MAX_OUT_LEN = DEF_MAX_OUT_LEN
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    ena,
    input  logic  [6:0]                             ui_param,
    input  tern_t [MAX_IN_LEN-1:0][MAX_OUT_LEN-1:0] ui_weights,
    input  logic                                    ui_ready,
    output logic  [OUT_W-1:0]                       uo_output,
    output logic                                    uo_valid,
    output logic                                    uo_phase,
`ifdef UNLOAD_PARITY_EN
    output logic                                    uo_done,
    output logic                                    uo_parity
`else
    output logic                                    uo_done
`endif
);

    unload_state_e    state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [3:0]       row_q, row_d;
    logic [2:0]       col_last_q, col_last_d;
    logic             ena_q;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             phase_q, phase_d;
    logic             done_q, done_d;
    logic             beat_load;
    logic             accept;
    logic [OUT_W-1:0] beat;

    assign accept = valid_q & ui_ready;

    // Beat for the state being entered, built from next-cycle selectors.
    tt_unload_beat_mux #(
        .MAX_IN_LEN (MAX_IN_LEN),
        .MAX_OUT_LEN(MAX_OUT_LEN)
    ) u_mux (
        .weights (ui_weights),
        .col     (count_d),
        .phase   (state_d == ST_LSB),
        .last_row(row_d),
        .beat    (beat)
    );

    // Next-state and output control; ena low aborts any active dump.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        row_d      = row_q;
        col_last_d = col_last_q;
        valid_d    = valid_q;
        phase_d    = phase_q;
        done_d     = 1'b0;
        beat_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                phase_d = 1'b0;
                if (ena && !ena_q) begin
                    row_d      = ui_param[6:3];
                    col_last_d = ui_param[2:0];
                    count_d    = '0;
                    state_d    = ST_MSB;
                    valid_d    = 1'b1;
                    beat_load  = 1'b1;
                end
            end
            ST_MSB: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    phase_d = 1'b0;
                    count_d = '0;
                end else if (accept) begin
                    state_d   = ST_LSB;
                    phase_d   = 1'b1;
                    beat_load = 1'b1;
                end
            end
            ST_LSB: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    phase_d = 1'b0;
                    count_d = '0;
                end else if (accept) begin
                    if (count_q < col_last_q) begin
                        count_d   = count_q + 3'd1;
                        state_d   = ST_MSB;
                        phase_d   = 1'b0;
                        beat_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        phase_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Output data: load a new beat, hold under backpressure, else zero.
    always_comb begin
        out_d = '0;
        if (valid_d) begin
            out_d = beat_load ? beat : out_q;
        end
    end

    // State, counters, latched dump shape and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            row_q      <= '0;
            col_last_q <= '0;
            ena_q      <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            phase_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            row_q      <= row_d;
            col_last_q <= col_last_d;
            ena_q      <= ena;
            out_q      <= out_d;
            valid_q    <= valid_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
        end
    end

    assign uo_output = out_q;
    assign uo_valid  = valid_q;
    assign uo_phase  = phase_q;
    assign uo_done   = done_q;

`ifdef UNLOAD_PARITY_EN
    logic parity_q;

    // Parity tracks the beat register; zero whenever no beat is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^out_d;
        end
    end

    assign uo_parity = parity_q;
`endif

endmodule
